// File: rtl/controlador_display.sv
// Scan controller for a 4-digit common-anode seven-segment display.
// One shared hex decoder, per-slot dead-time blanking, and display updates only at frame boundaries.
module controlador_display #(
    parameter int PRESCALE     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] valor,
    input  logic [3:0]  dp,
    input  logic        supr_ceros,
    input  logic        carga,
    output logic [7:0]  seg,
    output logic [3:0]  anodo,
    output logic        fin_trama
);

    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYCLES);

    logic [CNT_W-1:0] cnt;
    logic [1:0]       idx;
    logic             fin_slot;
    logic             frontera;

    logic [15:0] sh_valor;
    logic [3:0]  sh_dp;
    logic        sh_supr;
    logic        pend;

    logic [15:0] d_valor;
    logic [3:0]  d_dp;
    logic        d_supr;

    logic [3:0]  nib;
    logic [3:0]  cero;
    logic [3:0]  blanco;
    logic [7:0]  patron;

    // Active-low gfedcba pattern for one hex digit.
    function automatic logic [6:0] hex_a_seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    assign fin_slot = (cnt == CNT_MAX);
    assign frontera = fin_slot && (idx == 2'd3);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
            idx <= 2'd0;
        end else if (fin_slot) begin
            cnt <= '0;
            idx <= idx + 2'd1;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // A strobe on the boundary cycle bypasses the shadow so it is not delayed a whole frame.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sh_valor  <= '0;
            sh_dp     <= '0;
            sh_supr   <= 1'b0;
            pend      <= 1'b0;
            d_valor   <= '0;
            d_dp      <= '0;
            d_supr    <= 1'b0;
            fin_trama <= 1'b0;
        end else begin
            fin_trama <= frontera;
            if (carga) begin
                sh_valor <= valor;
                sh_dp    <= dp;
                sh_supr  <= supr_ceros;
            end
            if (frontera) begin
                pend <= 1'b0;
                if (carga) begin
                    d_valor <= valor;
                    d_dp    <= dp;
                    d_supr  <= supr_ceros;
                end else if (pend) begin
                    d_valor <= sh_valor;
                    d_dp    <= sh_dp;
                    d_supr  <= sh_supr;
                end
            end else if (carga) begin
                pend <= 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cero[i] = (d_valor[4*i +: 4] == 4'h0);
        end
        blanco[0] = 1'b0;
        blanco[3] = d_supr & cero[3];
        blanco[2] = blanco[3] & cero[2];
        blanco[1] = blanco[2] & cero[1];
        nib       = d_valor[{idx, 2'b00} +: 4];
        patron    = {~d_dp[idx], blanco[idx] ? 7'h7F : hex_a_seg(nib)};
    end

    // Output register: lags the counters by one cycle, dark during the dead-time window.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg   <= 8'hFF;
            anodo <= 4'b1111;
        end else if (cnt < BLANK_END) begin
            seg   <= 8'hFF;
            anodo <= 4'b1111;
        end else begin
            seg   <= patron;
            anodo <= ~(4'b0001 << idx);
        end
    end

endmodule

// File: tb/tb_controlador_display.sv
// Directed bench for controlador_display: expected slot patterns are queued per frame
// and popped by a monitor at the start of every lit digit slot.
module tb_controlador_display;

    localparam int PRESCALE = 8;
    localparam int BLANK    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] valor;
    logic [3:0]  dp;
    logic        supr_ceros;
    logic        carga;
    logic [7:0]  seg;
    logic [3:0]  anodo;
    logic        fin_trama;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [11:0] sb_q[$];
    bit          mon_en = 1'b0;

    logic [7:0] tabla [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    controlador_display #(.PRESCALE(PRESCALE), .BLANK_CYCLES(BLANK)) dut (
        .clk        (clk),
        .reset      (reset),
        .valor      (valor),
        .dp         (dp),
        .supr_ceros (supr_ceros),
        .carga      (carga),
        .seg        (seg),
        .anodo      (anodo),
        .fin_trama  (fin_trama)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] modelo_seg(input logic [15:0] v, input logic [3:0] p,
                                              input logic s, input int i);
        logic [15:0] alto;
        logic [7:0]  r;
        alto = v >> (4 * i);
        r    = tabla[alto[3:0]];
        if (s && i > 0 && alto == 16'h0) r = 8'hFF;
        if (p[i]) r[7] = 1'b0;
        return r;
    endfunction

    task automatic push_frame(input logic [15:0] v, input logic [3:0] p, input logic s);
        for (int i = 0; i < 4; i++) begin
            sb_q.push_back({~(4'b0001 << i), modelo_seg(v, p, s, i)});
        end
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] p, input logic s);
        @(negedge clk);
        valor      = v;
        dp         = p;
        supr_ceros = s;
        carga      = 1'b1;
        @(negedge clk);
        carga      = 1'b0;
    endtask

    task automatic wait_frame();
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (fin_trama !== 1'b1 && k < 100);
        if (fin_trama !== 1'b1) begin
            n_checks++;
            n_fail++;
            $error("FAIL frame_timeout: got no fin_trama, want pulse within 100 cycles");
        end
    endtask

    task automatic frame_done();
        wait_frame();
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
    endtask

    // Monitor: slot contents from the scoreboard, lit/blank run lengths, frame period.
    int          lit_len, blk_len, fin_gap;
    logic [3:0]  prev;
    logic [11:0] e;
    always @(negedge clk) begin
        if (reset || !mon_en) begin
            lit_len = -1;
            blk_len = -1;
            fin_gap = -1;
            prev    = 4'hF;
        end else begin
            if (fin_gap >= 0) fin_gap++;
            if (fin_trama === 1'b1) begin
                if (fin_gap >= 0) chk("frame_period", 32'(fin_gap), 32'(4 * PRESCALE));
                fin_gap = 0;
            end
            if (anodo == 4'hF) begin
                if (prev != 4'hF) begin
                    if (lit_len >= 0) chk("lit_cycles", 32'(lit_len), 32'(PRESCALE - BLANK));
                    blk_len = 1;
                end else if (blk_len >= 0) begin
                    blk_len++;
                end
            end else if (prev == 4'hF) begin
                if (blk_len >= 0) chk("blank_cycles", 32'(blk_len), 32'(BLANK));
                lit_len = 1;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    chk("slot_anodo", 32'(anodo), 32'(e[11:8]));
                    chk("slot_seg", 32'(seg), 32'(e[7:0]));
                end
            end else if (anodo == prev) begin
                if (lit_len >= 0) lit_len++;
            end else begin
                chk("anodo_overlap", 32'(anodo), 32'hF);
            end
            prev = anodo;
        end
    end

    initial begin
        reset      = 1'b1;
        carga      = 1'b0;
        valor      = 16'h0;
        dp         = 4'h0;
        supr_ceros = 1'b0;

        // 1: reset state and first lit digit after release
        repeat (3) @(negedge clk);
        chk("rst_seg", 32'(seg), 32'hFF);
        chk("rst_anodo", 32'(anodo), 32'hF);
        chk("rst_fin", 32'(fin_trama), 32'h0);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("post_rst_blank", 32'(anodo), 32'hF);
        @(negedge clk);
        chk("first_lit_anodo", 32'(anodo), 32'hE);
        chk("first_lit_seg", 32'(seg), 32'hC0);

        // 2: plain hex value
        load(16'h12AF, 4'b0000, 1'b0);
        wait_frame();
        push_frame(16'h12AF, 4'b0000, 1'b0);
        frame_done();

        // 3: leading-zero suppression with a dp on a blanked digit
        load(16'h0070, 4'b1000, 1'b1);
        wait_frame();
        push_frame(16'h0070, 4'b1000, 1'b1);
        frame_done();

        // 4: mid-frame loads wait for the boundary; last load wins
        load(16'h1111, 4'b0000, 1'b0);
        wait_frame();
        push_frame(16'h1111, 4'b0000, 1'b0);
        load(16'h5555, 4'b0000, 1'b0);
        frame_done();
        push_frame(16'h5555, 4'b0000, 1'b0);
        load(16'h1234, 4'b0000, 1'b0);
        load(16'h9ABC, 4'b0000, 1'b0);
        frame_done();

        // 5: load on the boundary cycle bypasses a pending shadow
        push_frame(16'h9ABC, 4'b0000, 1'b0);
        load(16'h4444, 4'b0000, 1'b0);
        repeat (28) @(negedge clk);
        load(16'hBEEF, 4'b0101, 1'b0);
        chk("bypass_fin", 32'(fin_trama), 32'h1);
        chk("bypass_pend", 32'(dut.pend), 32'h0);
        chk("queue_drained", 32'(sb_q.size()), 32'd0);
        push_frame(16'hBEEF, 4'b0101, 1'b0);
        frame_done();

        // 6: asynchronous reset while digit 2 is lit; pending shadow is lost
        load(16'h7777, 4'b0000, 1'b0);
        repeat (18) @(negedge clk);
        chk("digit2_anodo", 32'(anodo), 32'hB);
        chk("digit2_seg", 32'(seg), 32'h06);
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        chk("async_rst_anodo", 32'(anodo), 32'hF);
        chk("async_rst_seg", 32'(seg), 32'hFF);
        chk("async_rst_fin", 32'(fin_trama), 32'h0);
        repeat (2) @(negedge clk);
        reset  = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        chk("rerst_blank", 32'(anodo), 32'hF);
        @(negedge clk);
        chk("rerst_anodo", 32'(anodo), 32'hE);
        chk("rerst_seg", 32'(seg), 32'hC0);
        chk("rerst_pend", 32'(dut.pend), 32'h0);
        wait_frame();
        push_frame(16'h0000, 4'b0000, 1'b0);
        frame_done();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
